// File: rtl/pipearch_common_pkg.sv
// Shared definitions for the pipearch blocks: controller state encoding and
// the layout of the regs0 operand word.
package pipearch_common;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam int REGS0_LINES_LSB = 0;
    localparam int REGS0_LINES_W   = 16;
    localparam int REGS0_ITERS_LSB = 16;
    localparam int REGS0_ITERS_W   = 16;

    // Lines per iteration times iteration count; a 16x16 product always fits in 32 bits.
    function automatic logic [31:0] op_total(input logic [31:0] regs0);
        logic [31:0] lines;
        logic [31:0] iters;
        lines = {16'd0, regs0[REGS0_LINES_LSB +: REGS0_LINES_W]};
        iters = {16'd0, regs0[REGS0_ITERS_LSB +: REGS0_ITERS_W]};
        return lines * iters;
    endfunction

endpackage

// File: rtl/pipearch_readforward.sv
// Forwards upstream read requests to the memory region for a fixed number of
// lines per operation and returns responses upstream with one cycle of latency.
module pipearch_readforward
    import pipearch_common::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    output logic                  op_done,
    input  logic [31:0]           regs0,
    input  logic                  fwd_re,
    input  logic [ADDR_WIDTH-1:0] fwd_raddr,
    input  logic                  fwd_rfifobram,
    output logic                  fwd_almostfull,
    output logic                  fwd_rvalid,
    output logic [DATA_WIDTH-1:0] fwd_rdata,
    output logic                  rd_re,
    output logic [ADDR_WIDTH-1:0] rd_raddr,
    output logic                  rd_rfifobram,
    input  logic                  rd_almostfull,
    input  logic                  rd_rvalid,
    input  logic [DATA_WIDTH-1:0] rd_rdata
);

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_total;
    logic [31:0]           r_issued;
    logic [31:0]           r_returned;
    logic                  r_op_done;
    logic                  r_rd_re;
    logic [ADDR_WIDTH-1:0] r_rd_raddr;
    logic                  r_rd_rfifobram;
    logic                  r_fwd_rvalid;
    logic [DATA_WIDTH-1:0] r_fwd_rdata;

    logic [31:0]           w_op_total;
    logic                  w_start;
    logic                  w_start_empty;
    logic                  w_accept;
    logic                  w_resp;
    logic                  w_complete;
    logic                  w_issue_full;

    assign w_op_total    = op_total(regs0);
    assign w_start       = (r_state == ST_IDLE) && op_start;
    assign w_start_empty = w_start && (w_op_total == 32'd0);
    assign w_issue_full  = (r_issued == r_total);
    assign w_accept      = (r_state == ST_FORWARD) && fwd_re && !w_issue_full;
    assign w_resp        = (r_state != ST_IDLE) && rd_rvalid;
    assign w_complete    = w_resp && ((r_returned + 32'd1) == r_total);

    assign fwd_almostfull = rd_almostfull || (r_state != ST_FORWARD) || w_issue_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start && !w_start_empty) w_state_next = ST_FORWARD;
            end
            ST_FORWARD: begin
                if (w_complete)                                     w_state_next = ST_IDLE;
                else if (w_accept && (r_issued + 32'd1) == r_total) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_complete) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counters only move while an operation is active; a new start reloads them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total    <= 32'd0;
            r_issued   <= 32'd0;
            r_returned <= 32'd0;
        end else if (w_start) begin
            r_total    <= w_op_total;
            r_issued   <= 32'd0;
            r_returned <= 32'd0;
        end else begin
            if (w_accept) r_issued   <= r_issued + 32'd1;
            if (w_resp)   r_returned <= r_returned + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_done    <= 1'b0;
            r_rd_re      <= 1'b0;
            r_fwd_rvalid <= 1'b0;
        end else begin
            r_op_done    <= w_start_empty || w_complete;
            r_rd_re      <= w_accept;
            r_fwd_rvalid <= rd_rvalid;
        end
    end

    // NOTE: address and data registers carry no reset; they are only
    // meaningful alongside their valid strobes, which are reset.
    always_ff @(posedge clk) begin
        r_fwd_rdata <= rd_rdata;
        if (fwd_re) begin
            r_rd_raddr     <= fwd_raddr;
            r_rd_rfifobram <= fwd_rfifobram;
        end
    end

    assign op_done      = r_op_done;
    assign rd_re        = r_rd_re;
    assign rd_raddr     = r_rd_raddr;
    assign rd_rfifobram = r_rd_rfifobram;
    assign fwd_rvalid   = r_fwd_rvalid;
    assign fwd_rdata    = r_fwd_rdata;

endmodule

// File: tb/tb_pipearch_readforward.sv
// Self-checking bench for pipearch_readforward: directed scenarios plus random
// traffic against a counting reference model and an emulated memory region.
module tb_pipearch_readforward;

    localparam int DW = 512;
    localparam int AW = 16;

    logic          clk;
    logic          reset;
    logic          op_start;
    logic          op_done;
    logic [31:0]   regs0;
    logic          fwd_re;
    logic [AW-1:0] fwd_raddr;
    logic          fwd_rfifobram;
    logic          fwd_almostfull;
    logic          fwd_rvalid;
    logic [DW-1:0] fwd_rdata;
    logic          rd_re;
    logic [AW-1:0] rd_raddr;
    logic          rd_rfifobram;
    logic          rd_almostfull;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;

    pipearch_readforward #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .op_start       (op_start),
        .op_done        (op_done),
        .regs0          (regs0),
        .fwd_re         (fwd_re),
        .fwd_raddr      (fwd_raddr),
        .fwd_rfifobram  (fwd_rfifobram),
        .fwd_almostfull (fwd_almostfull),
        .fwd_rvalid     (fwd_rvalid),
        .fwd_rdata      (fwd_rdata),
        .rd_re          (rd_re),
        .rd_raddr       (rd_raddr),
        .rd_rfifobram   (rd_rfifobram),
        .rd_almostfull  (rd_almostfull),
        .rd_rvalid      (rd_rvalid),
        .rd_rdata       (rd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    resp_t       rq[$];
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_errors;
    int          n_re;
    int          n_fv;
    int          n_done;
    // Reference model: an operation is a count of lines to issue and to receive.
    bit          m_busy;
    int unsigned m_total;
    int unsigned m_issued;
    int unsigned m_returned;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic model_af();
        return rd_almostfull || !m_busy || (m_issued == m_total);
    endfunction

    // One clock: region drives its response, expectations are formed from the
    // inputs and the model, then registered outputs are compared after the edge.
    task automatic tick();
        logic          exp_re, exp_done, exp_fv, exp_fb;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic          start, accept, resp, complete;
        int unsigned   tot;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            rd_rvalid = 1'b1;
            rd_rdata  = rq[0].data;
            void'(rq.pop_front());
        end else begin
            rd_rvalid = 1'b0;
            rd_rdata  = rand_line();
        end
        #1;
        check("fwd_almostfull", DW'(fwd_almostfull), DW'(model_af()));
        exp_addr = fwd_raddr;
        exp_fb   = fwd_rfifobram;
        exp_data = rd_rdata;
        if (reset) begin
            exp_re     = 1'b0;
            exp_done   = 1'b0;
            exp_fv     = 1'b0;
            m_busy     = 1'b0;
            m_total    = 0;
            m_issued   = 0;
            m_returned = 0;
        end else begin
            tot      = int'(regs0[15:0]) * int'(regs0[31:16]);
            start    = !m_busy && op_start;
            accept   = m_busy && fwd_re && (m_issued < m_total);
            resp     = m_busy && rd_rvalid;
            complete = resp && (m_returned + 1 == m_total);
            exp_re   = accept;
            exp_done = (start && tot == 0) || complete;
            exp_fv   = rd_rvalid;
            if (start) begin
                if (tot != 0) begin
                    m_busy     = 1'b1;
                    m_total    = tot;
                    m_issued   = 0;
                    m_returned = 0;
                end
            end else begin
                if (accept)   m_issued++;
                if (resp)     m_returned++;
                if (complete) m_busy = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("rd_re", DW'(rd_re), DW'(exp_re));
        if (exp_re) begin
            check("rd_raddr", DW'(rd_raddr), DW'(exp_addr));
            check("rd_rfifobram", DW'(rd_rfifobram), DW'(exp_fb));
        end
        check("op_done", DW'(op_done), DW'(exp_done));
        check("fwd_rvalid", DW'(fwd_rvalid), DW'(exp_fv));
        if (exp_fv) check("fwd_rdata", fwd_rdata, exp_data);
        if (rd_re === 1'b1) begin
            rq.push_back('{due: cyc + lat - 1, data: rand_line()});
            n_re++;
        end
        if (fwd_rvalid === 1'b1) n_fv++;
        if (op_done === 1'b1) n_done++;
        op_start = 1'b0;
        fwd_re   = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] r0, input int l);
        lat      = l;
        regs0    = r0;
        op_start = 1'b1;
        tick();
    endtask

    task automatic send(input logic [AW-1:0] addr);
        fwd_re        = 1'b1;
        fwd_raddr     = addr;
        fwd_rfifobram = 1'($urandom);
        tick();
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((m_busy || rq.size() != 0) && i < 300) begin
            tick();
            i++;
        end
        check(tag, DW'(m_busy || rq.size() != 0), DW'(0));
    endtask

    task automatic clear_counts();
        n_re   = 0;
        n_fv   = 0;
        n_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_checks = 0; n_errors = 0; cyc = 0; lat = 1;
        reset = 1'b1; op_start = 1'b0; regs0 = 32'd0; fwd_re = 1'b0;
        fwd_raddr = '0; fwd_rfifobram = 1'b0; rd_almostfull = 1'b0;
        rd_rvalid = 1'b0; rd_rdata = '0;
        m_busy = 1'b0; m_total = 0; m_issued = 0; m_returned = 0;
        repeat (2) @(posedge clk);
        #1;
        clear_counts();

        // Reset state
        tick();
        reset = 1'b0;
        tick();
        check("reset_af", DW'(fwd_almostfull), DW'(1));

        // 2 iterations x 4 lines, back-to-back, region latency 3
        clear_counts();
        start_op(32'h0002_0004, 3);
        for (int i = 0; i < 8; i++) send(AW'(i));
        drain("s1_drain");
        check("s1_rd_re_count", DW'(n_re), DW'(8));
        check("s1_fwd_rvalid_count", DW'(n_fv), DW'(8));
        check("s1_op_done_count", DW'(n_done), DW'(1));

        // 3 lines, 5 requests: the last two are dropped
        clear_counts();
        start_op(32'h0001_0003, 2);
        for (int i = 0; i < 3; i++) send(AW'(16'h100 + i));
        check("s2_af_after_3rd", DW'(fwd_almostfull), DW'(1));
        send(AW'(16'h103));
        send(AW'(16'h104));
        drain("s2_drain");
        check("s2_rd_re_count", DW'(n_re), DW'(3));
        check("s2_op_done_count", DW'(n_done), DW'(1));

        // Region backpressure held for 10 cycles mid-operation
        clear_counts();
        start_op(32'h0003_0004, 2);
        k = 0;
        while (m_issued < m_total && k < 200) begin
            rd_almostfull = (k >= 3 && k < 13);
            if (!model_af() && ($urandom % 4 != 0)) send(AW'($urandom));
            else tick();
            k++;
        end
        rd_almostfull = 1'b0;
        drain("s3_drain");
        check("s3_rd_re_count", DW'(n_re), DW'(12));
        check("s3_fwd_rvalid_count", DW'(n_fv), DW'(12));
        check("s3_op_done_count", DW'(n_done), DW'(1));

        // Zero iterations: immediate completion
        clear_counts();
        start_op(32'h0000_0005, 1);
        tick();
        check("s4_op_done_count", DW'(n_done), DW'(1));
        check("s4_rd_re_count", DW'(n_re), DW'(0));

        // Reset mid-operation, then a fresh single-line operation
        clear_counts();
        start_op(32'h0001_0004, 3);
        send(AW'(16'h200));
        send(AW'(16'h201));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        check("s5_no_op_done", DW'(n_done), DW'(0));
        check("s5_idle_af", DW'(fwd_almostfull), DW'(1));
        clear_counts();
        start_op(32'h0001_0001, 2);
        send(AW'(16'h2A5));
        drain("s5_drain");
        check("s5_op_done_count", DW'(n_done), DW'(1));
        check("s5_rd_re_count", DW'(n_re), DW'(1));

        // Last request coincides with a response
        clear_counts();
        start_op(32'h0001_0002, 1);
        send(AW'(16'h300));
        send(AW'(16'h301));
        drain("s6_drain");
        check("s6_rd_re_count", DW'(n_re), DW'(2));
        check("s6_op_done_count", DW'(n_done), DW'(1));

        // Random operations with random backpressure, drops and stray starts
        clear_counts();
        for (int op = 0; op < 6; op++) begin
            start_op({16'($urandom_range(1, 3)), 16'($urandom_range(1, 3))}, $urandom_range(1, 4));
            k = 0;
            while (m_busy && k < 300) begin
                rd_almostfull = ($urandom % 5 == 0);
                if ($urandom % 8 == 0) begin
                    op_start = 1'b1;
                    regs0    = $urandom;
                end
                if (!model_af() && ($urandom % 3 != 0)) send(AW'($urandom));
                else if (!rd_almostfull && ($urandom % 4 == 0)) send(AW'($urandom));
                else tick();
                k++;
            end
            rd_almostfull = 1'b0;
            drain("s7_drain");
        end
        check("s7_op_done_count", DW'(n_done), DW'(6));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipearch_readforward.md
PIPEARCH_READFORWARD -- requirements
Module: pipearch_readforward

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, the read data line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the BRAM/FIFO address width in bits.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port op_start  input  1  one-cycle pulse that starts an operation.
REQ-006 SHALL have port op_done  output  1  one-cycle pulse when an operation completes.
REQ-007 SHALL have port regs0  input  32  operand word: [15:0] lines per iteration, [31:16] iteration count.
REQ-008 SHALL have port fwd_re  input  1  upstream read request.
REQ-009 SHALL have port fwd_raddr  input  ADDR_WIDTH  upstream read address.
REQ-010 SHALL have port fwd_rfifobram  input  1  upstream target select: 1 = FIFO, 0 = BRAM.
REQ-011 SHALL have port fwd_almostfull  output  1  backpressure to upstream; requests are only legal while it is low.
REQ-012 SHALL have port fwd_rvalid  output  1  response valid to upstream.
REQ-013 SHALL have port fwd_rdata  output  DATA_WIDTH  response data to upstream.
REQ-014 SHALL have port rd_re  output  1  read request to the region.
REQ-015 SHALL have port rd_raddr  output  ADDR_WIDTH  read address to the region.
REQ-016 SHALL have port rd_rfifobram  output  1  target select to the region.
REQ-017 SHALL have port rd_almostfull  input  1  region backpressure.
REQ-018 SHALL have port rd_rvalid  input  1  region response valid.
REQ-019 SHALL have port rd_rdata  input  DATA_WIDTH  region response data.

Function
REQ-020 SHALL implement states IDLE, FORWARD and DRAIN.
REQ-021 In IDLE, op_start SHALL latch regs0, compute total = lines*iterations (32-bit), clear all counters, and move to FORWARD.
REQ-022 If total == 0 at op_start, the block SHALL pulse op_done the next cycle and stay in IDLE.
REQ-023 In FORWARD, an fwd_re SHALL produce rd_re=1 exactly one cycle later, with rd_raddr and rd_rfifobram registered from the same cycle.
REQ-024 rd_re SHALL be 0 in every cycle except as required by REQ-023.
REQ-025 The block SHALL keep a 32-bit issued counter; fwd_re arriving while issued == total, or in IDLE or DRAIN, SHALL be dropped and not forwarded.
REQ-026 When issued reaches total, the block SHALL move to DRAIN.
REQ-027 fwd_almostfull SHALL be the combinational value rd_almostfull OR (state != FORWARD) OR (issued == total).
REQ-028 rd_rvalid/rd_rdata SHALL be registered to fwd_rvalid/fwd_rdata with one-cycle latency, in every state, without a ready/stall (no loss).
REQ-029 The block SHALL keep a 32-bit returned counter that increments on each rd_rvalid while an operation is active.
REQ-030 The operation SHALL complete in the cycle that returned reaches total, in FORWARD or DRAIN: op_done pulses for one cycle on the next edge and the state becomes IDLE.
REQ-031 A response and a request in the same cycle SHALL both be counted.
REQ-032 op_start outside IDLE SHALL be ignored.
REQ-033 Counters SHALL NOT wrap: issued saturates at total per REQ-025.

Reset
REQ-034 On reset, the state SHALL go to IDLE, op_done/rd_re/fwd_rvalid SHALL go to 0, and the counters SHALL be cleared.
REQ-035 On reset, data/address registers MAY hold any value.
REQ-036 Reset mid-operation SHALL abort the operation without an op_done pulse.
REQ-037 Responses arriving after reset SHALL still be forwarded on fwd_rvalid but not counted.

Structure
REQ-038 The state enum and the regs0 field offsets SHALL reside in the shared pipearch_common package.
REQ-039 The block SHALL be a single module with no sub-modules.

Verification
REQ-040 regs0 = 0x0002_0004, 8 back-to-back fwd_re at addresses 0..7, region latency 3 -> 8 rd_re (one cycle after each fwd_re) and 8 fwd_rvalid with matching data; op_done one cycle after the 8th response.
REQ-041 regs0 = 0x0001_0003, 5 requests -> only 3 rd_re; the 4th and 5th requests are dropped; fwd_almostfull = 1 after the 3rd request.
REQ-042 Hold rd_almostfull = 1 for 10 cycles mid-operation -> fwd_almostfull = 1 on the same cycles; no lost or duplicate requests.
REQ-043 regs0 = 0x0000_0005 -> op_done 1 cycle after op_start, no rd_re.
REQ-044 Assert reset after 2 of 4 requests -> IDLE, no op_done; a subsequent op_start with regs0 = 0x0001_0001 completes normally.
REQ-045 A request and a response in the same cycle on the last line -> both counted, single op_done.
